// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for a subset of ARM data-processing instructions.
// Sequences FETCH -> DECODE -> EXECUTE -> WRITEBACK and owns PC, IR, NZCV and the illegal flag.
module multicycle_control_unit #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = {WORD_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  in_Reset_n,
    output logic                  out_Fetch_req,
    input  logic                  in_Instr_valid,
    input  logic [31:0]           in_Instruction,
    input  logic [3:0]            in_Flags,
    output logic [WORD_WIDTH-1:0] out_Pc,
    output logic [3:0]            out_Rn,
    output logic [3:0]            out_Rm,
    output logic [3:0]            out_Rd,
    output logic [WORD_WIDTH-1:0] out_Imm,
    output logic                  out_Use_imm,
    output logic [3:0]            out_Alu_op,
    output logic                  out_Reg_write,
    output logic [3:0]            out_Flags,
    output logic [1:0]            out_State,
    output logic                  out_Illegal
);

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(4);

    // ARM condition field evaluated against NZCV = {N, Z, C, V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = !z;
            4'b0010: pass = c;
            4'b0011: pass = !c;
            4'b0100: pass = n;
            4'b0101: pass = !n;
            4'b0110: pass = v;
            4'b0111: pass = !v;
            4'b1000: pass = c && !z;
            4'b1001: pass = !c || z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = !z && (n == v);
            4'b1101: pass = z || (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // Rotated immediate: 8-bit value rotated right by twice the 4-bit rotate field.
    function automatic logic [31:0] rot_imm(input logic [11:0] field);
        logic [63:0] dbl;
        logic [5:0]  sh;
        sh  = {1'b0, field[11:8], 1'b0};
        dbl = {24'd0, field[7:0], 24'd0, field[7:0]} >> sh;
        return dbl[31:0];
    endfunction

    state_t                state_r;
    logic [31:0]           ir_r;
    logic [WORD_WIDTH-1:0] pc_r;
    logic [3:0]            flags_r;
    logic                  illegal_r;
    logic                  reg_write_r;
    logic                  fetch_req_r;

    logic                  cond_ok_s;
    logic                  is_compare_s;
    logic [WORD_WIDTH-1:0] pc_next_s;

    assign cond_ok_s    = cond_pass(ir_r[31:28], flags_r);
    assign is_compare_s = (ir_r[24:23] == 2'b10);
    assign pc_next_s    = pc_r + PC_STEP;

    // Sequencer: state, PC, IR, flags and strobes all update here.
    always_ff @(posedge clock or negedge in_Reset_n) begin
        if (!in_Reset_n) begin
            state_r     <= ST_FETCH;
            ir_r        <= 32'd0;
            pc_r        <= RESET_PC;
            flags_r     <= 4'd0;
            illegal_r   <= 1'b0;
            reg_write_r <= 1'b0;
            fetch_req_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    reg_write_r <= 1'b0;
                    // Valid is only honoured once the request is actually being presented.
                    if (fetch_req_r && in_Instr_valid) begin
                        ir_r        <= in_Instruction;
                        state_r     <= ST_DECODE;
                        fetch_req_r <= 1'b0;
                    end else begin
                        fetch_req_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    reg_write_r <= 1'b0;
                    if (!cond_ok_s) begin
                        pc_r        <= pc_next_s;
                        state_r     <= ST_FETCH;
                        fetch_req_r <= 1'b1;
                    end else if (ir_r[27:26] != 2'b00) begin
                        illegal_r   <= 1'b1;
                        pc_r        <= pc_next_s;
                        state_r     <= ST_FETCH;
                        fetch_req_r <= 1'b1;
                    end else begin
                        state_r     <= ST_EXECUTE;
                        fetch_req_r <= 1'b0;
                    end
                end
                ST_EXECUTE: begin
                    state_r     <= ST_WRITEBACK;
                    reg_write_r <= !is_compare_s;
                    fetch_req_r <= 1'b0;
                end
                ST_WRITEBACK: begin
                    reg_write_r <= 1'b0;
                    if (ir_r[20]) begin
                        flags_r <= in_Flags;
                    end else begin
                        flags_r <= flags_r;
                    end
                    pc_r        <= pc_next_s;
                    state_r     <= ST_FETCH;
                    fetch_req_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_FETCH;
                    reg_write_r <= 1'b0;
                    fetch_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_Fetch_req = fetch_req_r;
    assign out_Pc        = pc_r;
    assign out_Rn        = ir_r[19:16];
    assign out_Rm        = ir_r[3:0];
    assign out_Rd        = ir_r[15:12];
    assign out_Imm       = WORD_WIDTH'(rot_imm(ir_r[11:0]));
    assign out_Use_imm   = ir_r[25];
    assign out_Alu_op    = ir_r[24:21];
    assign out_Reg_write = reg_write_r;
    assign out_Flags     = flags_r;
    assign out_State     = state_r;
    assign out_Illegal   = illegal_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_multicycle_control_unit;

    logic        clock = 1'b0;
    logic        in_Reset_n;
    logic        out_Fetch_req;
    logic        in_Instr_valid;
    logic [31:0] in_Instruction;
    logic [3:0]  in_Flags;
    logic [31:0] out_Pc;
    logic [3:0]  out_Rn, out_Rm, out_Rd;
    logic [31:0] out_Imm;
    logic        out_Use_imm;
    logic [3:0]  out_Alu_op;
    logic        out_Reg_write;
    logic [3:0]  out_Flags;
    logic [1:0]  out_State;
    logic        out_Illegal;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_unit #(.WORD_WIDTH(32), .RESET_PC(32'd0)) dut (
        .clock(clock), .in_Reset_n(in_Reset_n), .out_Fetch_req(out_Fetch_req),
        .in_Instr_valid(in_Instr_valid), .in_Instruction(in_Instruction), .in_Flags(in_Flags),
        .out_Pc(out_Pc), .out_Rn(out_Rn), .out_Rm(out_Rm), .out_Rd(out_Rd), .out_Imm(out_Imm),
        .out_Use_imm(out_Use_imm), .out_Alu_op(out_Alu_op), .out_Reg_write(out_Reg_write),
        .out_Flags(out_Flags), .out_State(out_State), .out_Illegal(out_Illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction for one cycle; returns sitting in DECODE.
    task automatic fetch(input logic [31:0] instr);
        in_Instr_valid = 1'b1;
        in_Instruction = instr;
        tick();
        in_Instr_valid = 1'b0;
        in_Instruction = 32'd0;
    endtask

    initial begin
        in_Reset_n     = 1'b0;
        in_Instr_valid = 1'b0;
        in_Instruction = 32'd0;
        in_Flags       = 4'd0;
        #2;
        chk("rst_state", 32'(out_State), 32'd0);
        chk("rst_pc", out_Pc, 32'd0);
        chk("rst_flags", 32'(out_Flags), 32'd0);
        chk("rst_illegal", 32'(out_Illegal), 32'd0);
        chk("rst_regwr", 32'(out_Reg_write), 32'd0);
        chk("rst_fetchreq", 32'(out_Fetch_req), 32'd0);
        chk("rst_ir_rd", 32'(out_Rd), 32'd0);
        tick();
        in_Reset_n = 1'b1;
        tick();
        chk("post_rst_fetchreq", 32'(out_Fetch_req), 32'd1);
        chk("post_rst_state", 32'(out_State), 32'd0);

        // ADDEQ with Z=0: skipped in two cycles
        fetch(32'h0280_0004);
        chk("skip_decode_state", 32'(out_State), 32'd1);
        chk("skip_decode_regwr", 32'(out_Reg_write), 32'd0);
        tick();
        chk("skip_fetch_state", 32'(out_State), 32'd0);
        chk("skip_pc", out_Pc, 32'd4);
        chk("skip_regwr", 32'(out_Reg_write), 32'd0);

        // ADD R0,R0,#4
        fetch(32'hE280_0004);
        chk("add_rn", 32'(out_Rn), 32'd0);
        chk("add_rd", 32'(out_Rd), 32'd0);
        chk("add_rm", 32'(out_Rm), 32'd4);
        chk("add_imm", out_Imm, 32'd4);
        chk("add_useimm", 32'(out_Use_imm), 32'd1);
        chk("add_aluop", 32'(out_Alu_op), 32'b0100);
        tick();
        chk("add_exec_state", 32'(out_State), 32'd2);
        chk("add_exec_regwr", 32'(out_Reg_write), 32'd0);
        tick();
        chk("add_wb_state", 32'(out_State), 32'd3);
        chk("add_wb_regwr", 32'(out_Reg_write), 32'd1);
        tick();
        chk("add_done_state", 32'(out_State), 32'd0);
        chk("add_done_regwr", 32'(out_Reg_write), 32'd0);
        chk("add_done_pc", out_Pc, 32'd8);
        chk("add_hold_imm", out_Imm, 32'd4);

        // CMP R1,#0 loads flags 0100 and does not write
        in_Flags = 4'b0100;
        fetch(32'hE351_0000);
        chk("cmp_rn", 32'(out_Rn), 32'd1);
        chk("cmp_aluop", 32'(out_Alu_op), 32'b1010);
        tick();
        tick();
        chk("cmp_wb_regwr", 32'(out_Reg_write), 32'd0);
        chk("cmp_wb_flags_old", 32'(out_Flags), 32'd0);
        tick();
        chk("cmp_flags", 32'(out_Flags), 32'b0100);
        chk("cmp_pc", out_Pc, 32'd12);
        in_Flags = 4'b1111;

        // ADDEQ now passes on Z=1; S=0 leaves flags alone
        fetch(32'h0280_0004);
        tick();
        tick();
        chk("addeq_wb_regwr", 32'(out_Reg_write), 32'd1);
        tick();
        chk("addeq_pc", out_Pc, 32'd16);
        chk("addeq_flags", 32'(out_Flags), 32'b0100);

        // MOV R2,#0xFF000000
        fetch(32'hE3A0_24FF);
        chk("mov_imm", out_Imm, 32'hFF00_0000);
        chk("mov_rd", 32'(out_Rd), 32'd2);
        tick();
        tick();
        chk("mov_wb_regwr", 32'(out_Reg_write), 32'd1);
        tick();
        chk("mov_pc", out_Pc, 32'd20);

        // Same MOV with a three-cycle fetch stall
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_state", 32'(out_State), 32'd0);
            chk("stall_fetchreq", 32'(out_Fetch_req), 32'd1);
        end
        fetch(32'hE3A0_24FF);
        chk("stall_decode_state", 32'(out_State), 32'd1);
        tick();
        tick();
        chk("stall_wb_regwr", 32'(out_Reg_write), 32'd1);
        tick();
        chk("stall_pc", out_Pc, 32'd24);

        // LDR is illegal and sticky
        fetch(32'hE590_0000);
        chk("ldr_decode_illegal", 32'(out_Illegal), 32'd0);
        tick();
        chk("ldr_illegal", 32'(out_Illegal), 32'd1);
        chk("ldr_state", 32'(out_State), 32'd0);
        chk("ldr_pc", out_Pc, 32'd28);
        chk("ldr_regwr", 32'(out_Reg_write), 32'd0);

        // Condition NV is always skipped
        fetch(32'hF280_0004);
        tick();
        chk("nv_state", 32'(out_State), 32'd0);
        chk("nv_pc", out_Pc, 32'd32);
        chk("nv_illegal_sticky", 32'(out_Illegal), 32'd1);

        // Reset asserted during EXECUTE of ADD aborts it
        fetch(32'hE280_0004);
        tick();
        chk("abort_exec_state", 32'(out_State), 32'd2);
        in_Reset_n = 1'b0;
        #2;
        chk("abort_pc", out_Pc, 32'd0);
        chk("abort_state", 32'(out_State), 32'd0);
        chk("abort_flags", 32'(out_Flags), 32'd0);
        chk("abort_illegal", 32'(out_Illegal), 32'd0);
        chk("abort_regwr", 32'(out_Reg_write), 32'd0);
        chk("abort_fetchreq", 32'(out_Fetch_req), 32'd0);
        tick();
        chk("abort_hold_regwr", 32'(out_Reg_write), 32'd0);
        in_Reset_n = 1'b1;
        tick();
        chk("abort_rel_fetchreq", 32'(out_Fetch_req), 32'd1);
        chk("abort_rel_regwr", 32'(out_Reg_write), 32'd0);
        chk("abort_rel_pc", out_Pc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
